// File: rtl/fifo_ptr_pkg.sv
// Shared pointer helpers for the dual-clock FIFO controllers.
package fifo_ptr_pkg;

    // Widest pointer the shared Gray decoder handles.
    localparam int MAX_PTR_W = 32;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } wr_ctrl_state_e;

    // Pointer width carries one extra wrap bit over the RAM address.
    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

    // Gray decode; callers zero-extend narrower pointers, which decodes identically.
    function automatic logic [MAX_PTR_W-1:0] gray_to_bin(input logic [MAX_PTR_W-1:0] gray);
        logic [MAX_PTR_W-1:0] bin;
        bin[MAX_PTR_W-1] = gray[MAX_PTR_W-1];
        for (int i = MAX_PTR_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/bin_to_gray.sv
// Binary to reflected Gray code converter.
module bin_to_gray #(
    parameter int CNTR_WIDTH = 5
) (
    input  logic [CNTR_WIDTH-1:0] bin_i,
    output logic [CNTR_WIDTH-1:0] gray_o
);

    assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/gray_ptr_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing clock domains.
module gray_ptr_sync #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] gray_o
);

    logic [WIDTH-1:0] sync_q [STAGES];

    // Shift the asynchronous pointer through the flop chain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= gray_i;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign gray_o = sync_q[STAGES-1];

endmodule

// File: rtl/async_fifo_wr_ctrl.sv
// Write-side pointer controller of a dual-clock FIFO (write clock domain only).
module async_fifo_wr_ctrl
    import fifo_ptr_pkg::*;
#(
    parameter int ADDR_WIDTH  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int AF_THRESH   = 2,
    localparam int PTR_W      = ptr_width(ADDR_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_valid_i,
    output logic                  wr_ready_o,
    output logic                  wr_en_o,
    output logic [ADDR_WIDTH-1:0] wr_addr_o,
    output logic [PTR_W-1:0]      wr_gray_ptr_o,
    input  logic [PTR_W-1:0]      rd_gray_ptr_i,
    output logic                  full_o,
    output logic                  almost_full_o,
    output logic [PTR_W-1:0]      fill_level_o,
    output logic                  overflow_o
);

    localparam int               DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [PTR_W-1:0] DEPTH_W   = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] AF_W      = PTR_W'(AF_THRESH);
    localparam logic [2:0]       INIT_LAST = 3'(SYNC_STAGES);

    wr_ctrl_state_e   state_q, state_d;
    logic [2:0]       init_cnt_q, init_cnt_d;
    logic [PTR_W-1:0] wr_bin_q, wr_bin_d;
    logic [PTR_W-1:0] wr_gray_q, wr_gray_d;
    logic [PTR_W-1:0] fill_q, fill_d;
    logic             full_q, full_d;
    logic             af_q, af_d;
    logic             ovf_q, ovf_d;

    logic             push;
    logic [PTR_W-1:0] rd_gray_s;
    logic [PTR_W-1:0] rd_bin_s;
    logic [PTR_W-1:0] rd_gray_full;

    gray_ptr_sync #(
        .WIDTH  (PTR_W),
        .STAGES (SYNC_STAGES)
    ) u_rd_sync (
        .clk    (clk),
        .reset  (reset),
        .gray_i (rd_gray_ptr_i),
        .gray_o (rd_gray_s)
    );

    bin_to_gray #(
        .CNTR_WIDTH (PTR_W)
    ) u_wr_b2g (
        .bin_i  (wr_bin_d),
        .gray_o (wr_gray_d)
    );

    // FSM next state: hold off pushes until the read-pointer synchroniser has flushed.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        wr_ready_o = 1'b0;
        unique case (state_q)
            INIT: begin
                if (init_cnt_q == INIT_LAST) begin
                    state_d = RUN;
                end else begin
                    init_cnt_d = init_cnt_q + 3'd1;
                end
            end
            RUN: begin
                wr_ready_o = ~full_q;
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    // Next pointer and status flags, all derived from the post-edge pointer values.
    always_comb begin
        push         = wr_valid_i & wr_ready_o;
        wr_bin_d     = wr_bin_q + {{(PTR_W-1){1'b0}}, push};
        rd_bin_s     = PTR_W'(gray_to_bin(MAX_PTR_W'(rd_gray_s)));
        rd_gray_full = {~rd_gray_s[PTR_W-1:PTR_W-2], rd_gray_s[PTR_W-3:0]};
        full_d       = (wr_gray_d == rd_gray_full);
        fill_d       = wr_bin_d - rd_bin_s;
        af_d         = ((DEPTH_W - fill_d) <= AF_W);
        ovf_d        = ovf_q | ((state_q == RUN) & wr_valid_i & full_q);
    end

    // FSM and init counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= INIT;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    // Write pointer, exported Gray pointer and registered status flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_bin_q  <= '0;
            wr_gray_q <= '0;
            fill_q    <= '0;
            full_q    <= 1'b0;
            af_q      <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            wr_bin_q  <= wr_bin_d;
            wr_gray_q <= wr_gray_d;
            fill_q    <= fill_d;
            full_q    <= full_d;
            af_q      <= af_d;
            ovf_q     <= ovf_d;
        end
    end

    assign wr_en_o       = push;
    assign wr_addr_o     = wr_bin_q[ADDR_WIDTH-1:0];
    assign wr_gray_ptr_o = wr_gray_q;
    assign full_o        = full_q;
    assign almost_full_o = af_q;
    assign fill_level_o  = fill_q;
    assign overflow_o    = ovf_q;

endmodule

// File: doc/async_fifo_wr_ctrl.md
Name: async_fifo_wr_ctrl

Overview:
- Write-side pointer controller for a dual-clock FIFO; lives entirely in the write clock domain.
- Accepts pushes via a valid/ready handshake, drives RAM write enable/address, and exports a registered Gray-coded write pointer to the read domain.
- Synchronises the read domain's Gray pointer and generates full, almost-full, fill level and a sticky overflow flag.
- Uses bin_to_gray for binary-to-Gray pointer conversion.

Parameters:
- ADDR_WIDTH, 4, RAM address width; FIFO depth DEPTH = 2**ADDR_WIDTH; pointer width PTR_W = ADDR_WIDTH+1.
- SYNC_STAGES, 2, flop stages on rd_gray_ptr_i; legal range 2..4.
- AF_THRESH, 2, almost_full_o asserts when free slots <= AF_THRESH; legal range 1..DEPTH-1.

Ports:
- clk  input  1  write-domain clock.
- reset  input  1  asynchronous, active-low reset.
- wr_valid_i  input  1  push request.
- wr_ready_o  output  1  controller can accept a push.
- wr_en_o  output  1  RAM write strobe.
- wr_addr_o  output  ADDR_WIDTH  RAM write address.
- wr_gray_ptr_o  output  PTR_W  registered Gray write pointer, to the read domain.
- rd_gray_ptr_i  input  PTR_W  Gray read pointer from the read domain (asynchronous).
- full_o  output  1  FIFO full.
- almost_full_o  output  1  free slots <= AF_THRESH.
- fill_level_o  output  PTR_W  conservative occupancy, 0..DEPTH.
- overflow_o  output  1  sticky: a push was attempted while not ready.

Behaviour:
- Reset (reset=0, async assert, sync deassert assumed upstream):
  - All flops clear: wr_bin=0, wr_gray_ptr_o=0, all sync stages=0.
  - full_o=0, almost_full_o=0, fill_level_o=0, overflow_o=0.
  - wr_ready_o=0; the FSM enters INIT.
- FSM states:
  - INIT: counts SYNC_STAGES+1 cycles after reset release so the synchroniser flushes, then goes to RUN. wr_ready_o=0 throughout.
  - RUN: wr_ready_o = ~full_o. No other transitions; only reset returns the FSM to INIT.
- Push and RAM interface:
  - push = wr_valid_i & wr_ready_o.
  - wr_en_o = push (combinational).
  - wr_addr_o = wr_bin[ADDR_WIDTH-1:0] before the increment.
- Pointer update, on push at the clock edge:
  - wr_bin <= wr_bin+1, modulo 2**PTR_W; wrap from 2**PTR_W-1 to 0 is natural.
  - wr_gray_ptr_o <= bin_to_gray(wr_bin+1) on the same edge.
  - The output is a flop: exactly one bit changes per push, and it is never driven combinationally.
- Read-pointer synchroniser:
  - rd_gray_ptr_i passes through SYNC_STAGES flops to give rd_gray_s.
  - rd_bin_s = gray_to_bin(rd_gray_s).
- Full detection, registered and computed from next-state values:
  - full_o <= (wr_gray_next == {~rd_gray_s[PTR_W-1:PTR_W-2], rd_gray_s[PTR_W-3:0]}).
  - Full asserts on the same edge as the DEPTH-th outstanding push, so no extra push is ever accepted.
  - Full deasserts no earlier than SYNC_STAGES+1 cycles after rd_gray_ptr_i changes (pessimistic by design).
- Fill level and almost-full, registered:
  - fill_level_o <= wr_bin_next - rd_bin_s, modulo 2**PTR_W; the result never exceeds DEPTH.
  - almost_full_o <= (DEPTH - fill_level_next <= AF_THRESH).
- Overflow:
  - overflow_o sets when wr_valid_i=1 and full_o=1 in RUN.
  - It stays set until reset.
  - wr_valid_i during INIT is not an overflow.
- Simultaneous events:
  - Push plus synced read advance in one cycle: both pointers are applied; fill level reflects both, and full is recomputed from both.
- Reset mid-operation:
  - Immediate clear to reset values; any in-flight push is dropped (wr_en_o=0 while reset=0).
  - The read domain must also be reset; the FIFO as a whole is not defined otherwise.

Decomposition:
- Package fifo_ptr_pkg holds:
  - function gray_to_bin(PTR_W);
  - typedef enum {INIT, RUN} wr_ctrl_state_e;
  - localparam helper ptr_width(ADDR_WIDTH).
- Sub-module bin_to_gray (CNTR_WIDTH=PTR_W) converts wr_bin+1.
- Natural second sub-module: gray_ptr_sync, the SYNC_STAGES flop chain, reused later by the read-side controller.

Test Plan:
- Reset, then hold wr_valid_i=1 with rd_gray_ptr_i=0 -> wr_ready_o=0 for exactly SYNC_STAGES+1=3 cycles; overflow_o=0; first push on cycle 4 writes wr_addr_o=0.
- 16 consecutive pushes, rd_gray_ptr_i=0 -> full_o=1 on the edge of the 16th push; fill_level_o=16; almost_full_o=1 from fill_level_o=14; wr_gray_ptr_o=5'b11000.
- While full, wr_valid_i=1 for 3 cycles -> wr_en_o=0, pointer unchanged, overflow_o=1 and held until reset.
- From full, set rd_gray_ptr_i=bin_to_gray(4) -> full_o=0 exactly 3 cycles later; fill_level_o=12; exactly 4 more pushes accepted, then full_o=1.
- Run 40 pushes against a tracking read pointer -> wr_bin wraps 31->0; wr_gray_ptr_o goes 5'b10000->5'b00000; a checker confirms one-bit Gray change per push and wr_addr_o wraps 15->0.
- Assert reset mid-burst with fill_level_o=7 -> all outputs return to reset values asynchronously in the same cycle; INIT repeats on release.
